// File: rtl/lcd_frame_writer_if.sv
// Host/controller bundle for the LCD frame writer.
// Signal names match the controller-facing pin names.
interface lcd_frame_writer_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       refresh;
  logic       busy;
  logic       start;
  logic       RS;
  logic [7:0] data;
  logic       done;

  modport master (
    output wr_en, wr_addr, wr_data, refresh, done,
    input  busy, start, RS, data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, refresh, done,
    output busy, start, RS, data
  );
endinterface

// File: rtl/lcd_frame_writer.sv
// 2x16 character frame buffer plus command sequencer
// that streams init and both text lines to an LCD controller.
module lcd_frame_writer #(
  parameter logic [17:0] DELAY = 18'h320C0,
  parameter logic [7:0]  FILL  = 8'h20
) (
  input logic             clk,
  input logic             reset,
  lcd_frame_writer_if.slave lcd
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, GAP
  } state_t;

  localparam logic [5:0] LAST_P1 = 6'd38;
  localparam logic [5:0] LINE1   = 6'd4;

  state_t      r_state;
  logic [5:0]  r_idx;
  logic [17:0] r_cnt;
  logic        r_pend;
  logic        r_auto;
  logic [7:0]  r_buf [32];

  logic [5:0]  w_off1;
  logic [5:0]  w_off2;
  logic [7:0]  w_data;
  logic        w_rs;
  logic        w_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++)
        r_buf[i] <= FILL;
    end else if (lcd.wr_en) begin
      r_buf[lcd.wr_addr] <= lcd.wr_data;
    end
  end

  // line 2 positions 16..31 sit at indices 22..37
  assign w_off1 = r_idx - 6'd5;
  assign w_off2 = r_idx - 6'd6;

  always_comb begin
    w_data = 8'h00;
    w_rs   = 1'b1;
    unique case (1'b1)
      (r_idx == 6'd0): begin
        w_data = 8'h3C; w_rs = 1'b0;
      end
      (r_idx == 6'd1): begin
        w_data = 8'h0C; w_rs = 1'b0;
      end
      (r_idx == 6'd2): begin
        w_data = 8'h06; w_rs = 1'b0;
      end
      (r_idx == 6'd3): begin
        w_data = 8'h01; w_rs = 1'b0;
      end
      (r_idx == 6'd4): begin
        w_data = 8'h80; w_rs = 1'b0;
      end
      (r_idx >= 6'd5 && r_idx <= 6'd20): begin
        w_data = r_buf[w_off1[4:0]];
      end
      (r_idx == 6'd21): begin
        w_data = 8'hC0; w_rs = 1'b0;
      end
      (r_idx >= 6'd22 && r_idx <= 6'd37): begin
        w_data = r_buf[w_off2[4:0]];
      end
      default: begin
        w_data = 8'h00; w_rs = 1'b1;
      end
    endcase
  end

  assign lcd.data  = w_data;
  assign lcd.RS    = w_rs;
  assign lcd.busy  = (r_state != IDLE);
  assign lcd.start = (r_state == ISSUE);

  assign w_req = r_pend | lcd.refresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 6'd0;
      r_cnt   <= 18'd0;
      r_pend  <= 1'b0;
      r_auto  <= 1'b1;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (r_auto) begin
            r_auto  <= 1'b0;
            r_idx   <= 6'd0;
            r_state <= ISSUE;
          end else if (lcd.refresh) begin
            r_idx   <= LINE1;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_pend  <= w_req;
          r_state <= WAIT;
        end
        WAIT: begin
          r_pend <= w_req;
          if (lcd.done) begin
            r_idx   <= r_idx + 6'd1;
            r_cnt   <= 18'd0;
            r_state <= GAP;
          end
        end
        GAP: begin
          if (r_cnt == DELAY) begin
            r_cnt <= 18'd0;
            if (r_idx != LAST_P1) begin
              r_pend  <= w_req;
              r_state <= ISSUE;
            end else if (w_req) begin
              // back-to-back pass, no idle cycle
              r_pend  <= 1'b0;
              r_idx   <= LINE1;
              r_state <= ISSUE;
            end else begin
              r_pend  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt  <= r_cnt + 18'd1;
            r_pend <= w_req;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
